trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Sequences every machine-mode trap entry and MRET return for the RV32IM core.
- Arbitrates synchronous exceptions, pending interrupts and MRET from the EX stage, then drains the pipeline.
- Issues a one-cycle trap strobe carrying PC/cause to csr_file, redirects fetch to mtvec or mepc, and owns mstatus.MIE/MPIE.

Parameters:
- FLUSH_CYCLES, 2, number of drain cycles between acceptance and commit; legal range 1..15.
- RESET_MIE, 0, reset value of mstatus.MIE.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- ex_valid_i  in  1  valid instruction present in EX this cycle
- ex_pc_i  in  32  PC of the EX instruction
- exc_instr_misalign_i  in  1  instruction address misaligned
- exc_illegal_i  in  1  illegal instruction
- exc_ebreak_i  in  1  EBREAK
- exc_load_misalign_i  in  1  load address misaligned
- exc_store_misalign_i  in  1  store address misaligned
- exc_ecall_i  in  1  ECALL from M-mode
- mret_i  in  1  MRET in EX
- irq_ext_i, irq_sw_i, irq_timer_i  in  1 each  level interrupt lines
- irq_en_i  in  3  mie enables {MEIE, MTIE, MSIE}
- mtvec_i  in  32  trap vector; [1:0]=MODE (0 direct, 1 vectored)
- mepc_i  in  32  current mepc from csr_file
- trap_o  out  1  one-cycle trap strobe to csr_file
- trap_pc_o  out  32  PC to latch into mepc
- trap_cause_o  out  32  mcause value
- redirect_valid_o  out  1  one-cycle fetch redirect
- redirect_pc_o  out  32  redirect target
- flush_o  out  1  kill IF/ID/EX contents
- stall_o  out  1  hold PC and pipeline registers
- mstatus_mie_o, mstatus_mpie_o  out  1 each  global interrupt enable state

Behaviour:
- Reset (async, rst=1): state IDLE; all strobes, flush_o and stall_o are 0; trap_pc_o, trap_cause_o and redirect_pc_o are 0; mstatus_mie_o=RESET_MIE; mstatus_mpie_o=0; drain counter is 0. Reset during DRAIN or COMMIT aborts the operation: no trap_o and no redirect are issued.
- Pending interrupt: irq_line & irq_en_i bit & mstatus_mie_o.
- Acceptance happens in IDLE only, when ex_valid_i=1. The highest-priority event is latched:
  - MEI (cause 0x8000000B)
  - MSI (0x80000003)
  - MTI (0x80000007)
  - instr misalign (0)
  - illegal (2)
  - ebreak (3)
  - ecall (11)
  - load misalign (4)
  - store misalign (6)
  - MRET
- Interrupts are taken before the EX instruction executes. For every trap, trap_pc_o = ex_pc_i.
- An exception or interrupt together with MRET: the trap wins and MRET is discarded. The pipeline re-executes it later.
- Acceptance at cycle T gives this timing:
  - DRAIN: cycles T+1..T+FLUSH_CYCLES; flush_o=1 and stall_o=1.
  - COMMIT: cycle T+FLUSH_CYCLES+1; flush_o=1, stall_o=0, redirect_valid_o=1.
  - For a trap, trap_o=1 in COMMIT.
  - Return to IDLE at T+FLUSH_CYCLES+2.
- Trap target:
  - If mtvec MODE=1 and the event is an interrupt: {mtvec[31:2],2'b00} + 4*code, 32-bit wrap.
  - Otherwise: {mtvec[31:2],2'b00}.
  - MODE values 2 and 3 are treated as 0.
- MRET target: mepc_i sampled in COMMIT, with bits [1:0] forced to 0.
- mstatus updates happen in COMMIT only:
  - Trap: MPIE<=MIE, MIE<=0.
  - MRET: MIE<=MPIE, MPIE<=1.
- While in DRAIN or COMMIT, all inputs except rst, mtvec_i and mepc_i are ignored. Events that are still present are re-evaluated in the first IDLE cycle.
- Interrupts deasserting after acceptance do not cancel the trap.
- Outputs are registered. trap_pc_o and trap_cause_o hold their last value outside COMMIT.

Decomposition:
- Shared package trap_pkg holds:
  - exception/interrupt cause code constants
  - the state enum {IDLE, DRAIN, COMMIT}
  - an event_kind enum {EV_NONE, EV_TRAP, EV_MRET}
- One combinational sub-module, trap_prio_enc: takes the event vector and produces valid, kind, interrupt flag and cause.
- FSM, drain counter and mstatus registers live in trap_controller.

Test Plan:
- Illegal at PC 0x100 with mtvec=0x200, FLUSH_CYCLES=2 -> flush_o and stall_o high for 2 cycles. Next cycle: trap_o=1, trap_pc_o=0x100, trap_cause_o=2, redirect_pc_o=0x200, MIE 1->0, MPIE=1.
- MIE=1, MEIE=1, irq_ext_i=1 and exc_ecall_i=1 at PC 0x40, mtvec=0x301 (vectored) -> cause 0x8000000B, trap_pc_o=0x40, redirect_pc_o=0x32C.
- MRET with mepc_i=0x104, MPIE=1, MIE=0 -> no trap_o; redirect_pc_o=0x104; MIE=1, MPIE=1.
- irq_timer_i=1 with MIE=0 or MTIE=0 -> no acceptance. Setting both to 1 -> trap with cause 0x80000007.
- ECALL at PC 0x80 while in DRAIN from an earlier illegal -> only the illegal commits. ECALL is accepted in the next IDLE cycle if still presented.
- rst asserted mid-DRAIN -> immediately IDLE, outputs at reset values, no trap_o or redirect pulse.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Contents: mcause codes, FSM state and event-kind enums, event vector,
// trap target helper. Pure definitions, no logic or storage.
package trap_pkg;

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;
  typedef enum logic [1:0] {EV_NONE, EV_TRAP, EV_MRET} event_kind_t;

  localparam logic [31:0] CAUSE_MEI            = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI            = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI            = 32'h8000_0007;
  localparam logic [31:0] CAUSE_INSTR_MISALIGN = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL        = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK         = 32'd3;
  localparam logic [31:0] CAUSE_LOAD_MISALIGN  = 32'd4;
  localparam logic [31:0] CAUSE_STORE_MISALIGN = 32'd6;
  localparam logic [31:0] CAUSE_ECALL_M        = 32'd11;

  // Interrupt entries are already qualified by enable bits and MIE.
  typedef struct packed {
    logic irq_ext;
    logic irq_sw;
    logic irq_timer;
    logic instr_misalign;
    logic illegal;
    logic ebreak;
    logic ecall;
    logic load_misalign;
    logic store_misalign;
    logic mret;
  } event_vec_t;

  // Vectored mode only offsets interrupts; MODE 2/3 fall back to direct.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic        is_irq,
                                              input logic [4:0]  code);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && is_irq)
      return base + {25'd0, code, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Priority encoder: picks the winning trap/MRET event from the event vector.
// Latency: combinational. Backpressure: none.
// Ports: ev (event vector) -> ev_valid, ev_kind, ev_irq, ev_cause.
module trap_prio_enc
  import trap_pkg::*;
(
  input  event_vec_t        ev,
  output logic              ev_valid,
  output event_kind_t       ev_kind,
  output logic              ev_irq,
  output logic [31:0]       ev_cause
);

  // Interrupts first (they pre-empt the EX instruction), then exceptions,
  // and MRET last so that any trap discards a concurrent MRET.
  always_comb begin
    ev_valid = 1'b1;
    ev_kind  = EV_TRAP;
    ev_irq   = 1'b0;
    ev_cause = '0;
    if (ev.irq_ext) begin
      ev_irq   = 1'b1;
      ev_cause = CAUSE_MEI;
    end else if (ev.irq_sw) begin
      ev_irq   = 1'b1;
      ev_cause = CAUSE_MSI;
    end else if (ev.irq_timer) begin
      ev_irq   = 1'b1;
      ev_cause = CAUSE_MTI;
    end else if (ev.instr_misalign) begin
      ev_cause = CAUSE_INSTR_MISALIGN;
    end else if (ev.illegal) begin
      ev_cause = CAUSE_ILLEGAL;
    end else if (ev.ebreak) begin
      ev_cause = CAUSE_EBREAK;
    end else if (ev.ecall) begin
      ev_cause = CAUSE_ECALL_M;
    end else if (ev.load_misalign) begin
      ev_cause = CAUSE_LOAD_MISALIGN;
    end else if (ev.store_misalign) begin
      ev_cause = CAUSE_STORE_MISALIGN;
    end else if (ev.mret) begin
      ev_kind = EV_MRET;
    end else begin
      ev_valid = 1'b0;
      ev_kind  = EV_NONE;
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Trap/MRET sequencer: accept in IDLE, drain FLUSH_CYCLES, commit strobe+redirect.
// Latency: trap_o/redirect_valid_o FLUSH_CYCLES+1 cycles after acceptance.
// Backpressure: inputs ignored outside IDLE; stall_o holds the pipe while draining.
// Ports: EX event inputs, irq lines/enables, mtvec_i/mepc_i in; trap strobe,
// redirect, flush/stall and mstatus MIE/MPIE out (all registered).
module trap_controller
  import trap_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter bit          RESET_MIE    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        exc_instr_misalign_i,
  input  logic        exc_illegal_i,
  input  logic        exc_ebreak_i,
  input  logic        exc_load_misalign_i,
  input  logic        exc_store_misalign_i,
  input  logic        exc_ecall_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic [2:0]  irq_en_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        trap_o,
  output logic [31:0] trap_pc_o,
  output logic [31:0] trap_cause_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        mstatus_mie_o,
  output logic        mstatus_mpie_o
);

  localparam logic [3:0] DRAIN_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  drain_cnt;
  event_vec_t  ev;
  logic        ev_valid, ev_irq, accept;
  event_kind_t ev_kind;
  logic [31:0] ev_cause;

  event_kind_t lat_kind;
  logic        lat_irq;
  logic [31:0] lat_cause, lat_pc, commit_target;
  logic        trap_d, redirect_d, flush_d, stall_d;

  // mie bit order is {MEIE, MTIE, MSIE}.
  always_comb begin
    ev.irq_ext        = irq_ext_i   & irq_en_i[2] & mstatus_mie_o;
    ev.irq_timer      = irq_timer_i & irq_en_i[1] & mstatus_mie_o;
    ev.irq_sw         = irq_sw_i    & irq_en_i[0] & mstatus_mie_o;
    ev.instr_misalign = exc_instr_misalign_i;
    ev.illegal        = exc_illegal_i;
    ev.ebreak         = exc_ebreak_i;
    ev.ecall          = exc_ecall_i;
    ev.load_misalign  = exc_load_misalign_i;
    ev.store_misalign = exc_store_misalign_i;
    ev.mret           = mret_i;
  end

  trap_prio_enc u_prio (
    .ev       (ev),
    .ev_valid (ev_valid),
    .ev_kind  (ev_kind),
    .ev_irq   (ev_irq),
    .ev_cause (ev_cause)
  );

  assign accept = (state == IDLE) && ex_valid_i && ev_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 4'd0) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state; registered below so every strobe
  // lines up with the state it describes.
  always_comb begin
    flush_d    = (state_nxt != IDLE);
    stall_d    = (state_nxt == DRAIN);
    redirect_d = (state_nxt == COMMIT);
    trap_d     = (state_nxt == COMMIT) && (lat_kind == EV_TRAP);
  end

  // mepc/mtvec are taken at the last drain edge so late CSR writes land.
  assign commit_target = (lat_kind == EV_MRET) ? (mepc_i & ~32'h3)
                       : trap_target(mtvec_i, lat_irq, lat_cause[4:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt        <= '0;
      lat_kind         <= EV_NONE;
      lat_irq          <= 1'b0;
      lat_cause        <= '0;
      lat_pc           <= '0;
      trap_o           <= 1'b0;
      redirect_valid_o <= 1'b0;
      flush_o          <= 1'b0;
      stall_o          <= 1'b0;
      trap_pc_o        <= '0;
      trap_cause_o     <= '0;
      redirect_pc_o    <= '0;
      mstatus_mie_o    <= RESET_MIE;
      mstatus_mpie_o   <= 1'b0;
    end else begin
      trap_o           <= trap_d;
      redirect_valid_o <= redirect_d;
      flush_o          <= flush_d;
      stall_o          <= stall_d;

      if (accept) begin
        lat_kind  <= ev_kind;
        lat_irq   <= ev_irq;
        lat_cause <= ev_cause;
        lat_pc    <= ex_pc_i;
        drain_cnt <= DRAIN_INIT;
      end else if (state == DRAIN && drain_cnt != 4'd0) begin
        drain_cnt <= drain_cnt - 4'd1;
      end

      if (state == DRAIN && state_nxt == COMMIT) begin
        redirect_pc_o <= commit_target;
        if (lat_kind == EV_TRAP) begin
          trap_pc_o    <= lat_pc;
          trap_cause_o <= lat_cause;
        end
      end

      // mstatus is written at the end of COMMIT, so a reset that lands
      // in DRAIN or COMMIT leaves it untouched by the aborted event.
      if (state == COMMIT) begin
        if (lat_kind == EV_TRAP) begin
          mstatus_mpie_o <= mstatus_mie_o;
          mstatus_mie_o  <= 1'b0;
        end else if (lat_kind == EV_MRET) begin
          mstatus_mie_o  <= mstatus_mpie_o;
          mstatus_mpie_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;
  import trap_pkg::*;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        exc_instr_misalign_i, exc_illegal_i, exc_ebreak_i;
  logic        exc_load_misalign_i, exc_store_misalign_i, exc_ecall_i, mret_i;
  logic        irq_ext_i, irq_sw_i, irq_timer_i;
  logic [2:0]  irq_en_i;
  logic [31:0] mtvec_i, mepc_i;
  logic        trap_o, redirect_valid_o, flush_o, stall_o;
  logic [31:0] trap_pc_o, trap_cause_o, redirect_pc_o;
  logic        mstatus_mie_o, mstatus_mpie_o;

  trap_controller #(.FLUSH_CYCLES(FC), .RESET_MIE(1'b0)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ex_valid_i           (ex_valid_i),
    .ex_pc_i              (ex_pc_i),
    .exc_instr_misalign_i (exc_instr_misalign_i),
    .exc_illegal_i        (exc_illegal_i),
    .exc_ebreak_i         (exc_ebreak_i),
    .exc_load_misalign_i  (exc_load_misalign_i),
    .exc_store_misalign_i (exc_store_misalign_i),
    .exc_ecall_i          (exc_ecall_i),
    .mret_i               (mret_i),
    .irq_ext_i            (irq_ext_i),
    .irq_sw_i             (irq_sw_i),
    .irq_timer_i          (irq_timer_i),
    .irq_en_i             (irq_en_i),
    .mtvec_i              (mtvec_i),
    .mepc_i               (mepc_i),
    .trap_o               (trap_o),
    .trap_pc_o            (trap_pc_o),
    .trap_cause_o         (trap_cause_o),
    .redirect_valid_o     (redirect_valid_o),
    .redirect_pc_o        (redirect_pc_o),
    .flush_o              (flush_o),
    .stall_o              (stall_o),
    .mstatus_mie_o        (mstatus_mie_o),
    .mstatus_mpie_o       (mstatus_mpie_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_trap;
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] target;
    logic        mie;
    logic        mpie;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic m_mie, m_mpie;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] target);
    exp_t e;
    m_mpie = m_mie;
    m_mie  = 1'b0;
    e.is_trap = 1'b1; e.pc = pc; e.cause = cause; e.target = target;
    e.mie = m_mie; e.mpie = m_mpie;
    sb.push_back(e);
  endtask

  task automatic push_mret(input logic [31:0] target);
    exp_t e;
    m_mie  = m_mpie;
    m_mpie = 1'b1;
    e.is_trap = 1'b0; e.pc = '0; e.cause = '0; e.target = target;
    e.mie = m_mie; e.mpie = m_mpie;
    sb.push_back(e);
  endtask

  task automatic clear_ev();
    ex_valid_i = 0; ex_pc_i = '0;
    exc_instr_misalign_i = 0; exc_illegal_i = 0; exc_ebreak_i = 0;
    exc_load_misalign_i = 0; exc_store_misalign_i = 0; exc_ecall_i = 0;
    mret_i = 0; irq_ext_i = 0; irq_sw_i = 0; irq_timer_i = 0;
  endtask

  task automatic set_ev(input logic [31:0] pc, input logic ext, input logic timer,
                        input logic ill, input logic ecall, input logic mret);
    ex_valid_i = 1; ex_pc_i = pc;
    irq_ext_i = ext; irq_timer_i = timer;
    exc_illegal_i = ill; exc_ecall_i = ecall; mret_i = mret;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops one scoreboard entry per redirect pulse; mstatus is checked on the
  // following cycle, after the commit edge.
  task automatic wait_commits(input int n);
    int   run    = 0;
    int   budget = 0;
    int   left   = n;
    exp_t e;
    while (left > 0 && budget < 80) begin
      @(negedge clk);
      budget++;
      if (flush_o && stall_o) run++;
      if (redirect_valid_o) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("trap_o", {31'd0, trap_o}, {31'd0, e.is_trap});
          check("drain_len", run, FC);
          check("commit_flush_stall", {30'd0, flush_o, stall_o}, 32'd2);
          check("redirect_pc", redirect_pc_o, e.target);
          if (e.is_trap) begin
            check("trap_pc", trap_pc_o, e.pc);
            check("trap_cause", trap_cause_o, e.cause);
          end
          @(negedge clk);
          budget++;
          check("mie", {31'd0, mstatus_mie_o}, {31'd0, e.mie});
          check("mpie", {31'd0, mstatus_mpie_o}, {31'd0, e.mpie});
          check("strobe_one_cycle", {30'd0, trap_o, redirect_valid_o}, 32'd0);
        end
        run = 0;
        left--;
      end else if (trap_o) begin
        check("stray_trap", 32'd1, 32'd0);
      end
    end
    if (left > 0) check("commit_timeout", left, 0);
  endtask

  task automatic check_idle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check(tag, {28'd0, flush_o, stall_o, trap_o, redirect_valid_o}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; clear_ev(); irq_en_i = '0; mtvec_i = '0; mepc_i = '0;
    m_mie = 1'b0; m_mpie = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {28'd0, trap_o, redirect_valid_o, flush_o, stall_o}, 32'd0);
    check("rst_trap_pc", trap_pc_o, 32'd0);
    check("rst_cause", trap_cause_o, 32'd0);
    check("rst_redirect_pc", redirect_pc_o, 32'd0);
    check("rst_mstatus", {30'd0, mstatus_mie_o, mstatus_mpie_o}, 32'd0);
    @(posedge clk); #1 rst = 0;
    step();

    // Two MRETs bring MIE up to 1; the second checks mepc[1:0] masking.
    mepc_i = 32'h104; set_ev(32'h500, 0, 0, 0, 0, 1); push_mret(32'h104);
    step(); clear_ev(); wait_commits(1);
    mepc_i = 32'h107; set_ev(32'h504, 0, 0, 0, 0, 1); push_mret(32'h104);
    step(); clear_ev(); wait_commits(1);

    // Illegal, direct mode.
    mtvec_i = 32'h200; set_ev(32'h100, 0, 0, 1, 0, 0); push_trap(32'h100, CAUSE_ILLEGAL, 32'h200);
    step(); clear_ev(); wait_commits(1);

    // MRET with MPIE=1, MIE=0.
    mepc_i = 32'h104; set_ev(32'h508, 0, 0, 0, 0, 1); push_mret(32'h104);
    step(); clear_ev(); wait_commits(1);

    // MEI beats ECALL and MRET; vectored target.
    mtvec_i = 32'h301; irq_en_i = 3'b100;
    set_ev(32'h40, 1, 0, 0, 1, 1); push_trap(32'h40, CAUSE_MEI, 32'h32C);
    step(); clear_ev(); wait_commits(1);

    // Timer pending but MIE=0: nothing accepted.
    irq_en_i = 3'b111; step(); set_ev(32'h600, 0, 1, 0, 0, 0);
    check_idle(3, "no_accept_mie0");
    step(); clear_ev();
    mepc_i = 32'h10; set_ev(32'h50c, 0, 0, 0, 0, 1); push_mret(32'h10);
    step(); clear_ev(); wait_commits(1);

    // MIE=1 but MTIE=0: nothing; then enable MTIE, MODE=2 acts as direct.
    irq_en_i = 3'b101; step(); set_ev(32'h600, 0, 1, 0, 0, 0);
    check_idle(3, "no_accept_mtie0");
    irq_en_i = 3'b010; mtvec_i = 32'h202;
    push_trap(32'h600, CAUSE_MTI, 32'h200);
    step(); clear_ev(); wait_commits(1);
    mepc_i = 32'h20; set_ev(32'h510, 0, 0, 0, 0, 1); push_mret(32'h20);
    step(); clear_ev(); wait_commits(1);

    // ECALL presented during DRAIN is ignored, then accepted in next IDLE.
    mtvec_i = 32'h401;
    push_trap(32'h100, CAUSE_ILLEGAL, 32'h400);
    push_trap(32'h80, CAUSE_ECALL_M, 32'h400);
    fork
      begin
        set_ev(32'h100, 0, 0, 1, 0, 0); step();
        clear_ev(); set_ev(32'h80, 0, 0, 0, 1, 0);
        repeat (FC + 2) step();
        clear_ev();
      end
      wait_commits(2);
    join

    // Raise MPIE so the reset check below sees it cleared.
    mepc_i = 32'h30; set_ev(32'h514, 0, 0, 0, 0, 1); push_mret(32'h30);
    step(); clear_ev(); wait_commits(1);

    // Reset mid-DRAIN aborts the trap.
    mtvec_i = 32'h200; set_ev(32'h700, 0, 0, 1, 0, 0);
    step(); clear_ev();
    @(negedge clk);
    check("drain_before_rst", {30'd0, flush_o, stall_o}, 32'd3);
    #1 rst = 1;
    #1;
    check("rst_mid_strobes", {28'd0, trap_o, redirect_valid_o, flush_o, stall_o}, 32'd0);
    check("rst_mid_mstatus", {30'd0, mstatus_mie_o, mstatus_mpie_o}, 32'd0);
    check("rst_mid_trap_pc", trap_pc_o, 32'd0);
    check("rst_mid_redirect_pc", redirect_pc_o, 32'd0);
    @(posedge clk); #1 rst = 0;
    check_idle(6, "no_pulse_after_rst");
    check("sb_leftover", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
